// File: rtl/generador_pwm_pkg.sv
// rtl/generador_pwm_pkg.sv - shared PWM defaults, state encoding and period helper
package generador_pwm_pkg;

    localparam int ANCHO_DEF = 12;
    localparam int DIV_DEF   = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } estado_t;

    // Clocks per full PWM period: 2^ancho counts, each lasting div clocks.
    function automatic longint periodo_clks(input int ancho, input int div);
        return (longint'(1) << ancho) * longint'(div);
    endfunction

endpackage

// File: rtl/generador_pwm_if.sv
// rtl/generador_pwm_if.sv - sample input and PWM output bundle of the generator
interface generador_pwm_if
    import generador_pwm_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
);
    logic             habilitar;
    logic [ANCHO-1:0] dato_pwm;
    logic             dato_valido;
    logic             pwm_out;
    logic             fin_periodo;
    logic             sobrescritura;

    modport master (
        output habilitar,
        output dato_pwm,
        output dato_valido,
        input  pwm_out,
        input  fin_periodo,
        input  sobrescritura
    );

    modport slave (
        input  habilitar,
        input  dato_pwm,
        input  dato_valido,
        output pwm_out,
        output fin_periodo,
        output sobrescritura
    );
endinterface

// File: rtl/generador_pwm_divisor_reloj.sv
// rtl/generador_pwm_divisor_reloj.sv - prescaler emitting a one-cycle tick every DIV enabled clocks
module divisor_reloj #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int AW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [AW-1:0] CUENTA_FIN = AW'(DIV - 1);

    logic [AW-1:0] cuenta;

    assign tick = en && (cuenta == CUENTA_FIN);

    // Held at zero while disabled so a restart always begins a full step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta <= '0;
        end else if (!en || tick) begin
            cuenta <= '0;
        end else begin
            cuenta <= cuenta + AW'(1);
        end
    end
endmodule

// File: rtl/generador_pwm.sv
// rtl/generador_pwm.sv - double-buffered PWM generator with prescaler and period-end strobe
module generador_pwm
    import generador_pwm_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF,
    parameter int DIV   = DIV_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    generador_pwm_if.slave  bus
);
    localparam logic [ANCHO-1:0] CUENTA_MAX = '1;

    estado_t          estado;
    estado_t          estado_sig;
    logic             en_presc;
    logic             arranque;
    logic             paso;
    logic             envuelve;
    logic             carga_activo;
    logic [ANCHO-1:0] contador;
    logic [ANCHO-1:0] duty_activo;
    logic [ANCHO-1:0] duty_sig;
    logic [ANCHO-1:0] sombra;
    logic             sombra_llena;
    logic             pwm_q;
    logic             fin_q;
    logic             sobres_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        en_presc   = 1'b0;
        arranque   = 1'b0;
        case (estado)
            IDLE: begin
                if (bus.habilitar) begin
                    estado_sig = RUN;
                    arranque   = 1'b1;
                end
            end
            RUN: begin
                if (!bus.habilitar) begin
                    estado_sig = IDLE;
                end else begin
                    en_presc = 1'b1;
                end
            end
            default: estado_sig = IDLE;
        endcase
    end

    divisor_reloj #(.DIV(DIV)) u_divisor (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_presc),
        .tick  (paso)
    );

    assign envuelve     = paso && (contador == CUENTA_MAX);
    assign carga_activo = envuelve || arranque;

    // A sample arriving on the load edge bypasses the shadow; a stale shadow keeps the old duty.
    always_comb begin
        duty_sig = duty_activo;
        if (bus.dato_valido) begin
            duty_sig = bus.dato_pwm;
        end else if (sombra_llena || arranque) begin
            duty_sig = sombra;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contador     <= '0;
            duty_activo  <= '0;
            sombra       <= '0;
            sombra_llena <= 1'b0;
            pwm_q        <= 1'b0;
            fin_q        <= 1'b0;
            sobres_q     <= 1'b0;
        end else begin
            if (!en_presc) begin
                contador <= '0;
            end else if (paso) begin
                contador <= contador + ANCHO'(1);
            end

            if (carga_activo) begin
                duty_activo <= duty_sig;
            end

            if (bus.dato_valido) begin
                sombra <= bus.dato_pwm;
            end

            if (carga_activo) begin
                sombra_llena <= 1'b0;
            end else if (bus.dato_valido) begin
                sombra_llena <= 1'b1;
            end

            fin_q    <= envuelve;
            sobres_q <= bus.dato_valido && sombra_llena && !carga_activo;
            pwm_q    <= en_presc && (contador < duty_activo);
        end
    end

    assign bus.pwm_out       = pwm_q;
    assign bus.fin_periodo   = fin_q;
    assign bus.sobrescritura = sobres_q;
endmodule

// File: tb/tb_generador_pwm.sv
// tb/tb_generador_pwm.sv - self-checking bench for generador_pwm
module tb_generador_pwm;
    import generador_pwm_pkg::*;

    typedef struct {
        logic [11:0] carga;
        int          altos_esp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hab_a = 1'b0;
    logic        hab_b = 1'b0;
    logic [11:0] dato = '0;
    logic        valido = 1'b0;
    logic        sel = 1'b0;
    logic        pwm_m, fin_m, sob_m;

    int checks = 0;
    int errores = 0;

    generador_pwm_if #(.ANCHO(12)) ia ();
    generador_pwm_if #(.ANCHO(12)) ib ();

    assign ia.habilitar   = hab_a;
    assign ia.dato_pwm    = dato;
    assign ia.dato_valido = valido;
    assign ib.habilitar   = hab_b;
    assign ib.dato_pwm    = dato;
    assign ib.dato_valido = valido;

    generador_pwm #(.ANCHO(12), .DIV(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    generador_pwm #(.ANCHO(12), .DIV(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    assign pwm_m = sel ? ib.pwm_out       : ia.pwm_out;
    assign fin_m = sel ? ib.fin_periodo   : ia.fin_periodo;
    assign sob_m = sel ? ib.sobrescritura : ia.sobrescritura;

    always #5 clk = ~clk;

    task automatic comprobar(input string nombre, input longint real_v, input longint esp);
        checks++;
        if (real_v != esp) begin
            errores++;
            $display("FAIL %s: got %0d, expected %0d", nombre, real_v, esp);
        end
    endtask

    // Steps one negedge at a time until fin_periodo, counting high clocks and overrun pulses;
    // loads v1/v2 on steps p1/p2 (step numbers start at 1 for the first negedge).
    task automatic medir(input int p1, input logic [11:0] v1, input int p2, input logic [11:0] v2,
                         output int altos, output int largo, output int sobres);
        bit fin_visto;
        fin_visto = 1'b0;
        altos = 0;
        largo = 0;
        sobres = 0;
        while (!fin_visto && largo < 20000) begin
            @(negedge clk);
            largo++;
            if (pwm_m) altos++;
            if (sob_m) sobres++;
            if (fin_m) fin_visto = 1'b1;
            valido = 1'b0;
            if (largo == p1) begin dato = v1; valido = 1'b1; end
            if (largo == p2) begin dato = v2; valido = 1'b1; end
        end
        valido = 1'b0;
        comprobar("fin_periodo_seen", fin_visto, 1);
    endtask

    vec_t tabla[4];
    int altos, largo, sobres, vistos_pwm, vistos_fin;

    initial begin
        tabla[0] = '{12'h000, 1024};
        tabla[1] = '{12'hFFF, 0};
        tabla[2] = '{12'h001, 4095};
        tabla[3] = '{12'h100, 1};

        repeat (3) @(negedge clk);
        comprobar("reset_pwm", ia.pwm_out, 0);
        comprobar("reset_fin", ia.fin_periodo, 0);
        comprobar("reset_sobres", ia.sobrescritura, 0);
        rst_n = 1'b1;

        // Idle: capture works but nothing runs.
        @(negedge clk);
        dato = 12'h800; valido = 1'b1;
        @(negedge clk);
        valido = 1'b0;
        vistos_pwm = 0; vistos_fin = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ia.pwm_out) vistos_pwm++;
            if (ia.fin_periodo) vistos_fin++;
        end
        comprobar("idle_pwm_high", vistos_pwm, 0);
        comprobar("idle_fin", vistos_fin, 0);

        // First period after enable uses the idle-captured 12'h800.
        hab_a = 1'b1;
        medir(100, 12'h400, -1, 12'h000, altos, largo, sobres);
        comprobar("entry_high", altos, 2048);
        comprobar("entry_len", largo, 4097);

        for (int i = 0; i < 4; i++) begin
            medir(50, tabla[i].carga, -1, 12'h000, altos, largo, sobres);
            comprobar($sformatf("vec%0d_high", i), altos, tabla[i].altos_esp);
            comprobar($sformatf("vec%0d_len", i), largo, 4096);
            comprobar($sformatf("vec%0d_sobres", i), sobres, 0);
        end

        // Mid-period change does not affect the current period.
        medir(2000, 12'hC00, -1, 12'h000, altos, largo, sobres);
        comprobar("midchange_cur_high", altos, 256);
        // Load coincident with the wrap edge goes straight to the active duty.
        medir(4095, 12'h555, -1, 12'h000, altos, largo, sobres);
        comprobar("midchange_next_high", altos, 3072);
        comprobar("wrap_load_sobres", sobres, 0);
        medir(10, 12'h010, 20, 12'h020, altos, largo, sobres);
        comprobar("bypass_high", altos, 1365);
        comprobar("overrun_pulses", sobres, 1);
        medir(-1, 12'h000, -1, 12'h000, altos, largo, sobres);
        comprobar("overrun_last_wins", altos, 32);
        medir(-1, 12'h000, -1, 12'h000, altos, largo, sobres);
        comprobar("retain_high", altos, 32);
        comprobar("retain_len", largo, 4096);

        // Disable mid high-phase.
        repeat (5) @(negedge clk);
        comprobar("pre_disable_pwm", ia.pwm_out, 1);
        hab_a = 1'b0;
        @(negedge clk);
        comprobar("disable_pwm", ia.pwm_out, 0);

        // Async reset mid high-phase.
        hab_a = 1'b1;
        repeat (4) @(negedge clk);
        comprobar("pre_reset_pwm", ia.pwm_out, 1);
        #2 rst_n = 1'b0;
        #1;
        comprobar("async_reset_pwm", ia.pwm_out, 0);
        comprobar("async_reset_fin", ia.fin_periodo, 0);
        hab_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Prescaler DIV=3 with duty 2.
        sel = 1'b1;
        @(negedge clk);
        dato = 12'h002; valido = 1'b1;
        @(negedge clk);
        valido = 1'b0;
        hab_b = 1'b1;
        medir(-1, 12'h000, -1, 12'h000, altos, largo, sobres);
        comprobar("div3_entry_high", altos, 6);
        comprobar("div3_entry_len", largo, periodo_clks(12, 3) + 1);
        medir(-1, 12'h000, -1, 12'h000, altos, largo, sobres);
        comprobar("div3_high", altos, 6);
        comprobar("div3_len", largo, periodo_clks(12, 3));
        @(negedge clk);
        comprobar("div3_fin_one_clk", ib.fin_periodo, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errores);
        $finish;
    end
endmodule

// File: doc/generador_pwm.md
Name: generador_pwm

Overview:
- Downstream stage of the 12-bit filter-output truncator; consumes its unsigned duty word and drives the single-bit PWM output to the power/audio stage.
- Free-running up-counter with prescaler, plus a double-buffered duty register. New samples take effect only at a period boundary, so the output never glitches mid-period.
- Emits a period-end strobe used upstream as the sample-request tick.

Parameters:
- ANCHO, 12, duty and counter width in bits; period = 2^ANCHO counts.
- DIV, 1, clock cycles per counter step (prescaler); legal range 1..65535.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- habilitar  input  1  run enable; low forces the IDLE state
- dato_pwm  input  ANCHO  unsigned duty from the truncator (0 = 0 %, 2^ANCHO-1 = max)
- dato_valido  input  1  one-cycle strobe; dato_pwm is captured into the shadow register
- pwm_out  output  1  registered PWM output
- fin_periodo  output  1  one-cycle pulse on the clock where the counter wraps to 0
- sobrescritura  output  1  one-cycle pulse when dato_valido arrives while the shadow register still holds an unconsumed sample

Behaviour:
- Reset (rst_n low, async):
  - Counter, prescaler, shadow and active duty all go to 0; the shadow-full flag clears.
  - pwm_out=0, fin_periodo=0, sobrescritura=0; state = IDLE.
- States:
  - IDLE: counter and prescaler held at 0, pwm_out=0. Shadow capture still works.
  - RUN.
  - IDLE->RUN when habilitar=1. On that same edge the active duty loads from the shadow and shadow-full clears.
  - RUN->IDLE as soon as habilitar=0, without finishing the period. pwm_out is 0 on the next clock.
- Prescaler:
  - In RUN it counts 0..DIV-1.
  - The counter advances on the clock where the prescaler equals DIV-1.
  - With DIV=1 the counter advances every clock.
- Counter:
  - Counts 0..2^ANCHO-1 and wraps to 0. No saturation.
- Wrap event (counter = 2^ANCHO-1 and a prescaler step):
  - Counter goes to 0.
  - Active duty loads from the shadow; shadow-full clears.
  - fin_periodo pulses for exactly one clk on the cycle the counter reads 0, regardless of DIV.
- Output:
  - pwm_out is registered: pwm_out(n+1) = (counter(n) < active_duty(n)).
  - Duty 0 gives a constant low output.
  - Duty 2^ANCHO-1 gives high for all but one count per period.
  - Output latency from counter value is 1 clk.
- Shadow capture:
  - On dato_valido, shadow <= dato_pwm and shadow-full is set.
  - If shadow-full is already set, sobrescritura pulses on the following clk; the last sample wins.
- Simultaneous dato_valido and wrap:
  - The incoming dato_pwm goes directly to the active duty (bypass).
  - Shadow-full stays clear; no sobrescritura pulse.
- No new sample by the wrap: active duty retains the previous value.
- Reset mid-period: immediate return to reset values; no partial-period output.

Decomposition:
- A shared PWM package holds:
  - default ANCHO (12)
  - default DIV
  - state encoding localparams IDLE/RUN
  - a function computing the period length 2^ANCHO * DIV, for benches
- One natural sub-module: divisor_reloj, the prescaler producing a one-cycle count-enable tick. It is reusable by other timing blocks.
- Everything else is flat in generador_pwm.

Test Plan:
- Reset/idle: rst_n=0 then 1, habilitar=0, dato_valido pulses with 12'h800 -> pwm_out stays 0, fin_periodo never pulses, shadow holds 12'h800.
- Basic duty:
  - ANCHO=12, DIV=1, load 12'h400, raise habilitar -> each 4096-clk period has exactly 1024 high clocks.
  - fin_periodo pulses every 4096 clks.
- Extremes:
  - Duty 0 -> pwm_out constantly 0.
  - Duty 12'hFFF -> 4095 high, 1 low per period.
  - No glitch across the wrap.
- Double buffering:
  - Mid-period, change from 12'h100 to 12'hC00 -> current period still 256 high; next period 3072 high.
  - dato_valido coincident with wrap -> new value used in the period starting at that wrap.
- Overrun: two dato_valido strobes within one period (12'h010 then 12'h020) -> sobrescritura pulses once; next period 32 high.
- Prescaler/disable:
  - DIV=3, duty 12'h002 -> period 12288 clks, 6 clks high.
  - Drop habilitar mid-period -> pwm_out 0 within 1 clk.
  - Async rst_n mid-high-phase -> pwm_out 0 immediately.
